cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) among the result producers: ALU, LSB and branch unit.
- Each producer hands results over with a valid/ready handshake into a one-entry holding slot.
- A round-robin scheduler picks one occupied slot per cycle and drives a registered broadcast of (rob_id, value).
- The RS, ROB and LSB wake up their dependent entries from this broadcast; the RS no longer snoops the producers directly.

Parameters:
NUM_SRC, 3, number of producers (index 0 = ALU, 1 = LSB, 2 = BRANCH)
ROB_ID_W, 5, ROB tag width
DATA_W, 32, result width

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; pipeline freezes when low
clear_flag  in  1  misprediction flush
src_valid  in  NUM_SRC  per-source result valid
src_rob_id  in  NUM_SRC*ROB_ID_W  packed tags; source i at bits [i*ROB_ID_W +: ROB_ID_W]
src_val  in  NUM_SRC*DATA_W  packed results, same packing
src_ready  out  NUM_SRC  per-source slot can accept
cdb_valid  out  1  broadcast valid
cdb_rob_id  out  ROB_ID_W  broadcast tag
cdb_val  out  DATA_W  broadcast value
cdb_src  out  2  index of the granted source

Behaviour:
- Clocking and reset are fixed:
  - Single clock clk_in; all state updates on posedge.
  - rst_in is synchronous and active-high.
- Reset values:
  - All slots empty; rr pointer = 0.
  - cdb_valid = 0, cdb_rob_id = 0, cdb_val = 0, cdb_src = 0.
  - src_ready = 0 while rst_in is high.
- Slot handshake:
  - src_ready[i] = rdy_in && !clear_flag && (slot i empty || slot i granted this cycle).
  - Transfer occurs on an edge where src_valid[i] && src_ready[i]; the slot loads the tag and value.
  - A producer holds its data until the transfer happens.
- Grant:
  - Combinational over occupied slots.
  - Search starts at the rr pointer and wraps modulo NUM_SRC; the first occupied slot wins.
  - If no slot is occupied, there is no grant.
- Output:
  - On an edge with a grant, cdb_* are loaded from the granted slot and cdb_valid = 1.
  - The granted slot empties, unless it refills on the same edge.
  - The pointer moves to (granted + 1) mod NUM_SRC.
  - On an edge with no grant, cdb_valid = 0 and the pointer is unchanged.
  - cdb_valid is a one-cycle pulse per broadcast; it is never held for a second cycle.
- Latency:
  - Data transferred at edge k is broadcast at the earliest after edge k+1.
  - Worst-case wait is NUM_SRC cycles.
  - Sustained throughput is 1 broadcast/cycle.
- Same slot granted and refilled on one edge: new data replaces old; no loss, no duplicate.
- rdy_in low:
  - No state changes; cdb_* hold their values.
  - src_ready = 0.
  - Consumers ignore cdb_valid while rdy_in is low.
- clear_flag high (with rdy_in high):
  - All slots emptied; incoming data that cycle is dropped.
  - cdb_valid <= 0; pointer <= 0.
  - clear_flag has priority over grant and accept.
- rst_in overrides everything, including mid-operation; there is no partial broadcast afterwards.
- cdb_rob_id and cdb_val are undefined-but-stable when cdb_valid = 0; they hold their last value.

Optional Feature:
CDB_STATS_EN
- Defined:
  - Adds output stat_bcast  out  NUM_SRC*32: per-source count of broadcasts.
  - Adds output stat_stall  out  NUM_SRC*32: per-source count of cycles with src_valid && !src_ready while rdy_in is high.
  - Counters are cleared by rst_in only, not by clear_flag, and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared constants go in const.v:
  - `CDB_SRC_ALU = 0, `CDB_SRC_LSB = 1, `CDB_SRC_BR = 2.
  - `CDB_NUM_SRC = 3.
  - ROB tag width, reusing the existing ROB width macro.
- One sub-module: rr_arbiter.
  - Purely combinational rotate-priority picker.
  - Inputs: request vector and pointer. Outputs: one-hot grant, index, any_grant.
  - Reusable later for the RS-to-ALU issue select.

Test Plan:
- Single source: reset, then ALU valid with rob_id=3, val=0xDEAD at edge 1 -> cdb_valid=1, rob_id=3, val=0xDEAD, src=0 after edge 2, for exactly one cycle.
- Fairness: all three sources valid continuously with distinct tags -> broadcast order ALU, LSB, BR, ALU, LSB, ...; no source waits more than 3 cycles; 1 broadcast/cycle.
- Back-pressure: LSB valid every cycle while ALU and BR are also busy -> LSB src_ready alternates as expected; every accepted tag is broadcast exactly once, in per-source order.
- Flush: three slots full and clear_flag pulsed -> cdb_valid=0 on the next cycle; no stale tag is ever broadcast; pointer=0, so the next ALU and LSB requests grant ALU first.
- Stall: rdy_in low for 4 cycles with pending slots -> outputs frozen and src_ready=0; traffic resumes with the same arbitration order.
- Reset mid-stream during sustained traffic -> next cycle cdb_valid=0 and all slots empty; with CDB_STATS_EN, counters read 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB source indices, widths and index-width helper
package cdb_arbiter_pkg;
    localparam int CDB_SRC_ALU = 0;
    localparam int CDB_SRC_LSB = 1;
    localparam int CDB_SRC_BR = 2;
    localparam int CDB_NUM_SRC = 3;
    localparam int ROB_WIDTH = 5;
    localparam int CDB_DATA_W = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_rr.sv
// rr_arbiter: combinational rotate-priority picker; the first request at or after ptr wins
module rr_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N = CDB_NUM_SRC,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any_gnt
);
    always_comb begin
        idx = '0;
        any_gnt = 1'b0;
        // Walk from farthest to nearest so the slot closest to ptr is assigned last and wins
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = IW'((int'(ptr) + k) % N);
                any_gnt = 1'b1;
            end
        end
        gnt = any_gnt ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry slot per producer, round-robin onto a registered CDB broadcast.
// Define CDB_STATS_EN to add per-source broadcast and stall counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = CDB_NUM_SRC,
    parameter int ROB_ID_W = ROB_WIDTH,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        clear_flag,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*ROB_ID_W-1:0] src_rob_id,
    input  logic [NUM_SRC*DATA_W-1:0]   src_val,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic                        cdb_valid,
    output logic [ROB_ID_W-1:0]         cdb_rob_id,
    output logic [DATA_W-1:0]           cdb_val,
    output logic [1:0]                  cdb_src
`ifdef CDB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]       stat_bcast,
    output logic [NUM_SRC*32-1:0]       stat_stall
`endif
);
    localparam int IW = idx_w(NUM_SRC);

    logic [NUM_SRC-1:0]  slot_full, gnt, accept;
    logic [ROB_ID_W-1:0] slot_tag [NUM_SRC];
    logic [DATA_W-1:0]   slot_val [NUM_SRC];
    logic [IW-1:0]       ptr, gnt_idx;
    logic                any_gnt;

    rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_rr (
        .req(slot_full),
        .ptr(ptr),
        .gnt(gnt),
        .idx(gnt_idx),
        .any_gnt(any_gnt)
    );

    // A granted slot drains on the same edge, so it can take new data immediately
    assign src_ready = (rdy_in && !clear_flag && !rst_in) ? (~slot_full | gnt) : '0;
    assign accept = src_valid & src_ready;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_full <= '0;
            ptr <= '0;
            cdb_valid <= 1'b0;
            cdb_rob_id <= '0;
            cdb_val <= '0;
            cdb_src <= '0;
        end else if (rdy_in) begin
            if (clear_flag) begin
                slot_full <= '0;
                ptr <= '0;
                cdb_valid <= 1'b0;
            end else begin
                slot_full <= (slot_full & ~gnt) | accept;
                cdb_valid <= any_gnt;
                if (any_gnt) begin
                    cdb_rob_id <= slot_tag[gnt_idx];
                    cdb_val <= slot_val[gnt_idx];
                    cdb_src <= 2'(gnt_idx);
                    ptr <= (gnt_idx == IW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                slot_tag[i] <= src_rob_id[i*ROB_ID_W +: ROB_ID_W];
                slot_val[i] <= src_val[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef CDB_STATS_EN
    logic [31:0] bcast_cnt [NUM_SRC];
    logic [31:0] stall_cnt [NUM_SRC];

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rst_in) begin
                bcast_cnt[i] <= '0;
                stall_cnt[i] <= '0;
            end else begin
                if (rdy_in && !clear_flag && gnt[i]) bcast_cnt[i] <= bcast_cnt[i] + 1'b1;
                if (rdy_in && src_valid[i] && !src_ready[i]) stall_cnt[i] <= stall_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_stat
        assign stat_bcast[g*32 +: 32] = bcast_cnt[g];
        assign stat_stall[g*32 +: 32] = stall_cnt[g];
    end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed table, hand-written single-source sequence and randomized model check
module tb_cdb_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_flag;
    logic [2:0]  src_valid;
    logic [14:0] src_rob_id;
    logic [95:0] src_val;
    logic [2:0]  src_ready;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_val;
    logic [1:0]  cdb_src;
`ifdef CDB_STATS_EN
    logic [95:0] stat_bcast, stat_stall;
`endif

    cdb_arbiter dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .clear_flag(clear_flag),
        .src_valid(src_valid),
        .src_rob_id(src_rob_id),
        .src_val(src_val),
        .src_ready(src_ready),
        .cdb_valid(cdb_valid),
        .cdb_rob_id(cdb_rob_id),
        .cdb_val(cdb_val),
        .cdb_src(cdb_src)
`ifdef CDB_STATS_EN
        ,
        .stat_bcast(stat_bcast),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tv(input logic [4:0] t);
        return (t == 5'd0) ? 32'h0 : (32'hBEEF0000 | 32'(t));
    endfunction

    typedef struct {
        logic rst, rdy, clr;
        logic [2:0] vld;
        logic [14:0] tags;
        logic [2:0] er;
        logic ecv;
        logic [4:0] etag;
        logic [1:0] esrc;
    } vec_t;

    vec_t vecs [21];

    bit          mf [3];
    logic [4:0]  mt [3];
    logic [31:0] mv [3];
    int          mp;
    logic        m_cv;
    logic [4:0]  m_tag;
    logic [31:0] m_val;
    logic [1:0]  m_src;
    bit          pend [3];
    logic [4:0]  ptag [3];
    logic [31:0] pval [3];

    initial begin
        // Single ALU result: accepted at edge 1, broadcast after edge 2 for one cycle
        rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0;
        src_valid = '0; src_rob_id = '0; src_val = '0;
        #1;
        chk("rst_ready", 32'(src_ready), 32'h0);
        @(posedge clk_in); #1;
        chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("rst_cdb_rob_id", 32'(cdb_rob_id), 32'h0);
        chk("rst_cdb_val", cdb_val, 32'h0);
        chk("rst_cdb_src", 32'(cdb_src), 32'h0);
        rst_in = 1'b0; src_valid = 3'b001; src_rob_id = 15'd3; src_val = 96'hDEAD;
        #1;
        chk("single_ready", 32'(src_ready), 32'h7);
        @(posedge clk_in); #1;
        src_valid = '0;
        chk("single_lat_valid", 32'(cdb_valid), 32'h0);
        @(posedge clk_in); #1;
        chk("single_valid", 32'(cdb_valid), 32'h1);
        chk("single_rob_id", 32'(cdb_rob_id), 32'h3);
        chk("single_val", cdb_val, 32'hDEAD);
        chk("single_src", 32'(cdb_src), 32'h0);
        @(posedge clk_in); #1;
        chk("single_pulse", 32'(cdb_valid), 32'h0);
        chk("single_hold_id", 32'(cdb_rob_id), 32'h3);

        // Fairness, flush, stall and mid-stream reset; tags packed {src2, src1, src0}
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b000, 1'b0, 5'd0,  2'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'b111, {5'd4, 5'd2, 5'd1},    3'b111, 1'b0, 5'd0,  2'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'b111, {5'd7, 5'd6, 5'd5},    3'b001, 1'b1, 5'd1,  2'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'b111, {5'd7, 5'd6, 5'd9},    3'b010, 1'b1, 5'd2,  2'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'b111, {5'd7, 5'd10, 5'd9},   3'b100, 1'b1, 5'd4,  2'd2};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'b111, {5'd11, 5'd10, 5'd9},  3'b001, 1'b1, 5'd5,  2'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 3'b111, {5'd11, 5'd10, 5'd13}, 3'b000, 1'b0, 5'd5,  2'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'b011, {5'd0, 5'd10, 5'd13},  3'b111, 1'b0, 5'd5,  2'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b101, 1'b1, 5'd13, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'b101, {5'd11, 5'd0, 5'd14},  3'b111, 1'b1, 5'd10, 2'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b000, 1'b1, 5'd10, 2'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b000, 1'b1, 5'd10, 2'd1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b000, 1'b1, 5'd10, 2'd1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b000, 1'b1, 5'd10, 2'd1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b110, 1'b1, 5'd11, 2'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b111, 1'b1, 5'd14, 2'd0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b111, 1'b0, 5'd14, 2'd0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 3'b111, {5'd22, 5'd21, 5'd20}, 3'b111, 1'b0, 5'd14, 2'd0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 3'b111, {5'd25, 5'd24, 5'd23}, 3'b010, 1'b1, 5'd21, 2'd1};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 3'b111, {5'd25, 5'd26, 5'd23}, 3'b000, 1'b0, 5'd0,  2'd0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 3'b000, {5'd0, 5'd0, 5'd0},    3'b111, 1'b0, 5'd0,  2'd0};

        for (int i = 0; i < 21; i++) begin
            rst_in = vecs[i].rst; rdy_in = vecs[i].rdy; clear_flag = vecs[i].clr;
            src_valid = vecs[i].vld; src_rob_id = vecs[i].tags;
            src_val = {tv(vecs[i].tags[14:10]), tv(vecs[i].tags[9:5]), tv(vecs[i].tags[4:0])};
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(src_ready), 32'(vecs[i].er));
            @(posedge clk_in); #1;
            chk($sformatf("vec%0d_valid", i), 32'(cdb_valid), 32'(vecs[i].ecv));
            chk($sformatf("vec%0d_rob_id", i), 32'(cdb_rob_id), 32'(vecs[i].etag));
            chk($sformatf("vec%0d_val", i), cdb_val, tv(vecs[i].etag));
            chk($sformatf("vec%0d_src", i), 32'(cdb_src), 32'(vecs[i].esrc));
`ifdef CDB_STATS_EN
            if (i == 19) begin
                chk("stat_bcast_rst", 32'(|stat_bcast), 32'h0);
                chk("stat_stall_rst", 32'(|stat_stall), 32'h0);
            end
`endif
        end

        // Randomized traffic against a slot-level reference model
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r, rd, c;
            logic [2:0] er;
            int w;
            r = (cyc == 0) || ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    ptag[i] = 5'($urandom);
                    pval[i] = $urandom;
                end
            end
            rst_in = r; rdy_in = rd; clear_flag = c;
            src_valid = {pend[2], pend[1], pend[0]};
            src_rob_id = {ptag[2], ptag[1], ptag[0]};
            src_val = {pval[2], pval[1], pval[0]};
            // Winner is the occupied slot at the smallest forward distance from the pointer
            w = -1;
            for (int d = 2; d >= 0; d--) if (mf[(mp + d) % 3]) w = (mp + d) % 3;
            for (int i = 0; i < 3; i++) er[i] = rd && !c && !r && (!mf[i] || i == w);
            #1;
            chk("rnd_ready", 32'(src_ready), 32'(er));
            @(posedge clk_in); #1;
            if (r) begin
                for (int i = 0; i < 3; i++) mf[i] = 1'b0;
                mp = 0; m_cv = 1'b0; m_tag = '0; m_val = '0; m_src = '0;
            end else if (rd) begin
                if (c) begin
                    for (int i = 0; i < 3; i++) mf[i] = 1'b0;
                    mp = 0; m_cv = 1'b0;
                end else begin
                    m_cv = (w >= 0);
                    if (w >= 0) begin
                        m_tag = mt[w]; m_val = mv[w]; m_src = 2'(w);
                        mf[w] = 1'b0;
                        mp = (w + 1) % 3;
                    end
                    for (int i = 0; i < 3; i++) begin
                        if (pend[i] && er[i]) begin
                            mf[i] = 1'b1; mt[i] = ptag[i]; mv[i] = pval[i];
                        end
                    end
                end
            end
            for (int i = 0; i < 3; i++) if (pend[i] && er[i]) pend[i] = 1'b0;
            chk("rnd_valid", 32'(cdb_valid), 32'(m_cv));
            chk("rnd_rob_id", 32'(cdb_rob_id), 32'(m_tag));
            chk("rnd_val", cdb_val, m_val);
            chk("rnd_src", 32'(cdb_src), 32'(m_src));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
